sisc_ctrl: RTL and testbench

//  Multicycle control FSM of the SISC processor; a processor-level instance alongside the alu, rf, pc, ir, br and dm blocks.

---
 rtl/sisc_pkg.sv | 73 +++++++
 rtl/sisc_br_cond.sv | 27 ++
 rtl/sisc_ctrl.sv | 128 ++++++++++++
 tb/tb_sisc_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multicycle controller.
// SISC_HALT_EN adds the HALT state reached by the HLT opcode.
package sisc_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned MM_W     = 4;
    localparam int unsigned STAT_W   = 4;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned ALU_OP_W = 2;

    // Status register layout {C,N,V,Z}
    localparam int unsigned STAT_C = 3;
    localparam int unsigned STAT_N = 2;
    localparam int unsigned STAT_V = 1;
    localparam int unsigned STAT_Z = 0;

    localparam logic [MM_W-1:0] AM_IMM = 4'b1000;

    typedef enum logic [OP_W-1:0] {
        OP_NOOP   = 4'd0,
        OP_REG_OP = 4'd1,
        OP_REG_IM = 4'd2,
        OP_BRA    = 4'd4,
        OP_BRR    = 4'd5,
        OP_BNE    = 4'd6,
        OP_BNR    = 4'd7,
        OP_LOD    = 4'd10,
        OP_STR    = 4'd11,
        OP_HLT    = 4'd15
    } sisc_op_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_RR   = 2'b00,
        ALU_RI   = 2'b01,
        ALU_ADDR = 2'b10,
        ALU_NONE = 2'b11
    } alu_op_e;

    typedef enum logic [STATE_W-1:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6
`ifdef SISC_HALT_EN
        ,
        S_HALT      = 3'd7
`endif
    } state_e;

    // ALU operation for an opcode; non-ALU opcodes default to reg-reg
    function automatic logic [ALU_OP_W-1:0] alu_op_for(input logic [OP_W-1:0] op);
        logic [ALU_OP_W-1:0] res;
        res = ALU_RR;
        case (op)
            OP_REG_IM:      res = ALU_RI;
            OP_LOD, OP_STR: res = ALU_ADDR;
            default:        res = ALU_RR;
        endcase
        return res;
    endfunction

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LOD) || (op == OP_STR);
    endfunction

    function automatic logic writes_rf(input logic [OP_W-1:0] op);
        return (op == OP_REG_OP) || (op == OP_REG_IM) || (op == OP_LOD);
    endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Branch resolution: decides whether a branch opcode is taken and how its
// target is formed (absolute imm vs pc-relative).
module sisc_br_cond
    import sisc_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [MM_W-1:0]   mm,
    input  logic [STAT_W-1:0] stat,
    output logic              taken_c,
    output logic              br_sel_c
);

    logic cond;
    logic br_if_set;
    logic br_if_clr;

    always_comb begin
        cond = (stat[STAT_C] & mm[STAT_C]) | (stat[STAT_N] & mm[STAT_N])
             | (stat[STAT_V] & mm[STAT_V]) | (stat[STAT_Z] & mm[STAT_Z]);
        br_if_set = (opcode == OP_BRA) || (opcode == OP_BRR);
        br_if_clr = (opcode == OP_BNE) || (opcode == OP_BNR);
        // A zero mask makes cond 0: BRA/BRR never, BNE/BNR always taken
        taken_c  = (br_if_set & cond) | (br_if_clr & ~cond);
        br_sel_c = (opcode == OP_BRA) || (opcode == OP_BNE);
    end

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multicycle control FSM: fetch/decode/execute/mem/writeback sequencing
// with outputs decoded from state and opcode. SISC_HALT_EN enables HALT.
module sisc_ctrl
    import sisc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_f,
    input  logic [OP_W-1:0]     opcode,
    input  logic [MM_W-1:0]     mm,
    input  logic [STAT_W-1:0]   stat,
    output logic                rf_we,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                wb_sel,
    output logic                rd_sel,
    output logic                pc_sel,
    output logic                pc_write,
    output logic                pc_rst,
    output logic                ir_load,
    output logic                br_sel,
    output logic                mm_sel,
    output logic                dm_we
);

    state_e state_q;
    state_e state_d;
    logic   taken_c;
    logic   br_sel_c;
    logic   is_branch;
    logic   mm_rel;

    sisc_br_cond u_br_cond (
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .taken_c  (taken_c),
        .br_sel_c (br_sel_c)
    );

    // Reset lands in START0 asynchronously so pc_rst asserts in the same cycle
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= S_START0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START0:    state_d = S_START1;
            S_START1:    state_d = S_FETCH;
            S_FETCH:     state_d = S_DECODE;
`ifdef SISC_HALT_EN
            S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            S_HALT:      state_d = S_HALT;
`else
            S_DECODE:    state_d = S_EXECUTE;
`endif
            S_EXECUTE:   state_d = S_MEM;
            S_MEM:       state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            default:     state_d = S_START0;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        alu_op   = ALU_RR;
        wb_sel   = 1'b0;
        rd_sel   = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        br_sel   = 1'b0;
        mm_sel   = 1'b0;
        dm_we    = 1'b0;

        is_branch = (opcode == OP_BRA) || (opcode == OP_BRR)
                 || (opcode == OP_BNE) || (opcode == OP_BNR);
        // Any mode other than absolute imm addresses memory via rsa+imm
        mm_rel = (mm != AM_IMM);

        case (state_q)
            S_START0: begin
                pc_rst = 1'b1;
            end
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                if (is_branch) begin
                    br_sel = br_sel_c;
                    if (taken_c) begin
                        pc_sel   = 1'b1;
                        pc_write = 1'b1;
                    end
                end
            end
            S_EXECUTE: begin
                alu_op = alu_op_for(opcode);
            end
            S_MEM: begin
                alu_op = alu_op_for(opcode);
                if (is_mem_op(opcode)) begin
                    mm_sel = mm_rel;
                end
                if (opcode == OP_STR) begin
                    dm_we  = 1'b1;
                    rd_sel = 1'b1;
                end
            end
            S_WRITEBACK: begin
                alu_op = alu_op_for(opcode);
                rf_we  = writes_rf(opcode);
                if (opcode == OP_LOD) begin
                    wb_sel = 1'b1;
                    mm_sel = mm_rel;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Directed bench for sisc_ctrl: checks the packed control vector state by state.
module tb_sisc_ctrl;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       rf_we;
    logic [1:0] alu_op;
    logic       wb_sel;
    logic       rd_sel;
    logic       pc_sel;
    logic       pc_write;
    logic       pc_rst;
    logic       ir_load;
    logic       br_sel;
    logic       mm_sel;
    logic       dm_we;

    int total = 0;
    int bad   = 0;

    // Vector layout {rf_we, alu_op[1:0], wb_sel, rd_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel, mm_sel, dm_we}
    localparam logic [11:0] NONE   = 12'h000;
    localparam logic [11:0] RFWE   = 12'h800;
    localparam logic [11:0] ALU_RI = 12'h200;
    localparam logic [11:0] ALU_AD = 12'h400;
    localparam logic [11:0] WBSEL  = 12'h100;
    localparam logic [11:0] RDSEL  = 12'h080;
    localparam logic [11:0] PCSEL  = 12'h040;
    localparam logic [11:0] PCW    = 12'h020;
    localparam logic [11:0] PCRST  = 12'h010;
    localparam logic [11:0] IRL    = 12'h008;
    localparam logic [11:0] BRSEL  = 12'h004;
    localparam logic [11:0] MMSEL  = 12'h002;
    localparam logic [11:0] DMWE   = 12'h001;

    logic [11:0] obs;
    assign obs = {rf_we, alu_op, wb_sel, rd_sel, pc_sel, pc_write, pc_rst,
                  ir_load, br_sel, mm_sel, dm_we};

    sisc_ctrl dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .rf_we    (rf_we),
        .alu_op   (alu_op),
        .wb_sel   (wb_sel),
        .rd_sel   (rd_sel),
        .pc_sel   (pc_sel),
        .pc_write (pc_write),
        .pc_rst   (pc_rst),
        .ir_load  (ir_load),
        .br_sel   (br_sel),
        .mm_sel   (mm_sel),
        .dm_we    (dm_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Entered with the FSM sampled in FETCH; leaves it sampled in the next FETCH
    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic [3:0] m, input logic [3:0] s,
                             input logic [11:0] e_dec, input logic [11:0] e_ex,
                             input logic [11:0] e_mem, input logic [11:0] e_wb);
        opcode = op;
        mm     = m;
        stat   = s;
        check({name, ".fetch"}, IRL | PCW);
        next_cycle();
        check({name, ".decode"}, e_dec);
        next_cycle();
        check({name, ".execute"}, e_ex);
        next_cycle();
        check({name, ".mem"}, e_mem);
        next_cycle();
        check({name, ".writeback"}, e_wb);
        next_cycle();
    endtask

    initial begin
        rst_f  = 1'b0;
        opcode = 4'd0;
        mm     = 4'd0;
        stat   = 4'd0;
        #1;
        check("reset", PCRST);
        #2;
        rst_f = 1'b1;
        #1;
        check("start0", PCRST);
        next_cycle();
        check("start1", NONE);
        next_cycle();

        run_instr("reg_op", 4'd1, 4'b0000, 4'b0000, NONE, NONE, NONE, RFWE);
        run_instr("reg_im", 4'd2, 4'b0000, 4'b0000, NONE, ALU_RI, ALU_RI, RFWE | ALU_RI);
        run_instr("bra_taken", 4'd4, 4'b0001, 4'b0001, PCSEL | PCW | BRSEL, NONE, NONE, NONE);
        run_instr("bra_not", 4'd4, 4'b0001, 4'b0000, BRSEL, NONE, NONE, NONE);
        run_instr("bnr_mm0", 4'd7, 4'b0000, 4'b1111, PCSEL | PCW, NONE, NONE, NONE);
        run_instr("bne_not", 4'd6, 4'b0100, 4'b0100, BRSEL, NONE, NONE, NONE);
        run_instr("brr_mm0", 4'd5, 4'b0000, 4'b1111, NONE, NONE, NONE, NONE);
        run_instr("brr_taken", 4'd5, 4'b1000, 4'b1000, PCSEL | PCW, NONE, NONE, NONE);
        run_instr("bne_taken", 4'd6, 4'b0010, 4'b0001, PCSEL | PCW | BRSEL, NONE, NONE, NONE);
        run_instr("str_abs", 4'd11, 4'b1000, 4'b0000, NONE, ALU_AD,
                  ALU_AD | RDSEL | DMWE, ALU_AD);
        run_instr("str_rel", 4'd11, 4'b0011, 4'b0000, NONE, ALU_AD,
                  ALU_AD | RDSEL | MMSEL | DMWE, ALU_AD);
        run_instr("lod_rel", 4'd10, 4'b0000, 4'b0000, NONE, ALU_AD,
                  ALU_AD | MMSEL, RFWE | ALU_AD | WBSEL | MMSEL);
        run_instr("lod_abs", 4'd10, 4'b1000, 4'b0000, NONE, ALU_AD,
                  ALU_AD, RFWE | ALU_AD | WBSEL);
        run_instr("op3_noop", 4'd3, 4'b1111, 4'b1111, NONE, NONE, NONE, NONE);
        run_instr("op12_noop", 4'd12, 4'b1000, 4'b0000, NONE, NONE, NONE, NONE);

        // Reset in the middle of EXECUTE must abort the write
        opcode = 4'd10;
        mm     = 4'b0000;
        check("rst_mid.fetch", IRL | PCW);
        next_cycle();
        next_cycle();
        check("rst_mid.execute", ALU_AD);
        #1;
        rst_f = 1'b0;
        #1;
        check("rst_mid.assert", PCRST);
        next_cycle();
        check("rst_mid.hold", PCRST);
        rst_f = 1'b1;
        #1;
        check("rst_mid.start0", PCRST);
        next_cycle();
        check("rst_mid.start1", NONE);
        next_cycle();
        check("rst_mid.fetch_again", IRL | PCW);

`ifdef SISC_HALT_EN
        opcode = 4'd15;
        next_cycle();
        check("hlt.decode", NONE);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check("hlt.halted", NONE);
        end
        rst_f = 1'b0;
        #1;
        check("hlt.reset", PCRST);
        #1;
        rst_f = 1'b1;
        next_cycle();
        check("hlt.start1", NONE);
        next_cycle();
        check("hlt.fetch", IRL | PCW);
`else
        run_instr("hlt_noop", 4'd15, 4'b0000, 4'b0000, NONE, NONE, NONE, NONE);
        check("hlt_noop.fetch_again", IRL | PCW);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
